kgp_mc_sequencer: RTL

Multi-cycle control sequencer for the KGP-RISC core. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB, and in each state drives the datapath strobes and the 4-bit ALUOp consumed by the ALU control decoder. It handshakes with instruction and data memory, which may be wait-stated, and stops in a sticky HALT on a halt or illegal opcode. It sits between the instruction register and the existing datapath.

---
 rtl/kgp_mc_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/kgp_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the KGP-RISC core.
// Optional retired-instruction counter enabled by defining KGP_SEQ_PERF_EN.
module kgp_mc_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_b,
    output logic [3:0]  ALUOp,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        halted,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic       r_illegal;
    logic       w_set_illegal;
    logic [5:0] w_op;
    logic [3:0] w_aluop;
    logic       w_is_imm;
    logic       w_is_ld;
    logic       w_is_st;
    logic       w_is_jump;
    logic       w_is_branch;
    logic       w_is_halt;
    logic       w_is_legal;
    logic       w_unused;

    assign w_op        = instr[31:26];
    assign w_unused    = ^instr[25:0];
    assign w_is_imm    = (w_op >= 6'd1) && (w_op <= 6'd8);
    assign w_is_ld     = (w_op == 6'd9);
    assign w_is_st     = (w_op == 6'd10);
    assign w_is_jump   = (w_op == 6'd12);
    assign w_is_branch = (w_op >= 6'd13) && (w_op <= 6'd16);
    assign w_is_halt   = (w_op == 6'd63);
    assign w_is_legal  = (w_op <= 6'd16) || w_is_halt;

    always_comb begin
        w_aluop = 4'b0000;
        case (w_op)
            6'd0:                       w_aluop = 4'b0010;
            6'd1:                       w_aluop = 4'b0000;
            6'd2:                       w_aluop = 4'b0001;
            6'd3:                       w_aluop = 4'b0100;
            6'd4:                       w_aluop = 4'b0101;
            6'd5:                       w_aluop = 4'b0110;
            6'd6:                       w_aluop = 4'b0111;
            6'd7:                       w_aluop = 4'b1000;
            6'd8:                       w_aluop = 4'b1001;
            6'd9, 6'd10:                w_aluop = 4'b1010;
            6'd11:                      w_aluop = 4'b1100;
            6'd13, 6'd14, 6'd15, 6'd16: w_aluop = 4'b1011;
            default:                    w_aluop = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StFetch;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // FETCH strobes are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        w_state_next  = r_state;
        w_set_illegal = 1'b0;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'b00;
        alu_src_b     = 1'b0;
        ALUOp         = 4'b0000;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        unique case (r_state)
            StFetch: begin
                imem_req = rst_n;
                if (imem_ack) begin
                    ir_write     = rst_n;
                    pc_write     = rst_n;
                    w_state_next = StDecode;
                end
            end
            StDecode: begin
                if (w_is_jump) begin
                    pc_write     = 1'b1;
                    pc_src       = 2'b10;
                    w_state_next = StFetch;
                end else if (w_is_halt) begin
                    w_state_next = StHalt;
                end else if (!w_is_legal) begin
                    w_set_illegal = 1'b1;
                    w_state_next  = StHalt;
                end else begin
                    w_state_next = StExec;
                end
            end
            StExec: begin
                ALUOp     = w_aluop;
                alu_src_b = w_is_imm | w_is_ld | w_is_st;
                if (w_is_branch) begin
                    pc_write     = zero;
                    pc_src       = zero ? 2'b01 : 2'b00;
                    w_state_next = StFetch;
                end else if (w_is_ld || w_is_st) begin
                    w_state_next = StMem;
                end else begin
                    w_state_next = StWb;
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_st;
                ALUOp    = 4'b1010;
                if (dmem_ack) begin
                    w_state_next = w_is_ld ? StWb : StFetch;
                end
            end
            StWb: begin
                reg_write    = 1'b1;
                mem_to_reg   = w_is_ld;
                w_state_next = StFetch;
            end
            StHalt: begin
                w_state_next = StHalt;
            end
            default: begin
                w_state_next = StFetch;
            end
        endcase
    end

    assign state   = r_state;
    assign halted  = (r_state == StHalt);
    assign illegal = r_illegal;

`ifdef KGP_SEQ_PERF_EN
    // Every completion path is a return to FETCH from some other state.
    logic [31:0] r_retired;
    logic        w_retire;

    assign w_retire = (r_state != StFetch) && (w_state_next == StFetch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= 32'd0;
        end else if (w_retire) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`else
    assign retired = 32'd0;
`endif

endmodule
